// File: rtl/hazard_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_ctrl
//
// Central hazard and sequencing controller for a 5-stage RV32I pipeline.
// Produces stall/flush controls for the PC and the F/D, D/E and E/M pipeline
// registers. Handles load-use hazards, taken branch/jump redirects (with an
// optional tail of extra fetch bubbles), instruction-memory wait states and
// multi-cycle mul/div occupancy of the Execute stage. Also keeps saturating
// stall-cycle and redirect performance counters.
//
// Parameters:
//   REDIRECT_CYCLES  extra cycles flush_D stays high after a redirect (0..15)
//   CNT_W            width of the performance counters
//
// Ports:
//   clk, rst         clock, synchronous active-high reset
//   rs1_D, rs2_D     source registers of the instruction in Decode
//   rd_E             destination register of the instruction in Execute
//   memread_E        instruction in Execute is a load
//   pc_sel_E         taken branch/jump resolved in Execute
//   imem_ready       instruction fetch data valid this cycle
//   md_start_E       mul/div instruction in Execute (level, held while in E)
//   md_done          mul/div result valid this cycle
//   cnt_clr          synchronous clear of both counters
//   stall_F/D/E      hold PC, F/D register, D/E register
//   flush_D/E/M      load a bubble into F/D, D/E, E/M
//   stall_cnt        number of cycles with stall_F=1 (saturating)
//   redir_cnt        number of accepted redirects (saturating)
//
// Handshake note: md_start_E/md_done form a level/pulse pair rather than a
// valid/ready channel. md_start_E stays high for as long as the mul/div op
// sits in Execute; md_done is a single-cycle pulse marking the cycle in which
// the result is valid and the op may leave Execute on the next edge.
//
// The FSM state is held in the internal signal `state` (encodings ST_*),
// which checkers can bind to directly.
// -----------------------------------------------------------------------------
module hazard_ctrl #(
    parameter int unsigned REDIRECT_CYCLES = 0,
    parameter int unsigned CNT_W           = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       rs1_D,
    input  logic [4:0]       rs2_D,
    input  logic [4:0]       rd_E,
    input  logic             memread_E,
    input  logic             pc_sel_E,
    input  logic             imem_ready,
    input  logic             md_start_E,
    input  logic             md_done,
    input  logic             cnt_clr,
    output logic             stall_F,
    output logic             stall_D,
    output logic             stall_E,
    output logic             flush_D,
    output logic             flush_E,
    output logic             flush_M,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] redir_cnt
);

    // -------------------------------------------------------------------------
    // State encodings
    // -------------------------------------------------------------------------
    localparam logic [1:0] ST_RUN      = 2'd0;
    localparam logic [1:0] ST_MD_WAIT  = 2'd1;
    localparam logic [1:0] ST_REDIRECT = 2'd2;

    localparam logic [3:0]       REDIR_LOAD = 4'(REDIRECT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};

    // -------------------------------------------------------------------------
    // Internal signals
    // -------------------------------------------------------------------------
    logic [1:0] state;
    logic [1:0] state_next;
    logic [3:0] redir_left;
    logic [3:0] redir_left_next;

    logic       load_use;
    logic       md_busy;
    logic       redirect_take;

    // -------------------------------------------------------------------------
    // Hazard detection terms
    // -------------------------------------------------------------------------
    // x0 is hardwired to zero, so a load targeting it never creates a hazard.
    assign load_use = memread_E && (rd_E != 5'd0) &&
                      ((rd_E == rs1_D) || (rd_E == rs2_D));

    // A mul/div that completes in the same cycle it is seen needs no stall.
    assign md_busy  = md_start_E && !md_done;

    // -------------------------------------------------------------------------
    // Control outputs and next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        stall_F         = 1'b0;
        stall_D         = 1'b0;
        stall_E         = 1'b0;
        flush_D         = 1'b0;
        flush_E         = 1'b0;
        flush_M         = 1'b0;
        redirect_take   = 1'b0;
        state_next      = state;
        redir_left_next = redir_left;

        case (state)
            ST_RUN: begin
                if (md_busy) begin
                    // Freeze F, D and E; feed bubbles into M behind the op.
                    stall_F    = 1'b1;
                    stall_D    = 1'b1;
                    stall_E    = 1'b1;
                    flush_M    = 1'b1;
                    state_next = ST_MD_WAIT;
                end else if (pc_sel_E) begin
                    // Squash the two wrong-path instructions in F/D and D/E.
                    flush_D       = 1'b1;
                    flush_E       = 1'b1;
                    redirect_take = 1'b1;
                    if (REDIRECT_CYCLES != 0) begin
                        state_next      = ST_REDIRECT;
                        redir_left_next = REDIR_LOAD;
                    end
                end else if (load_use) begin
                    // One bubble lets the load reach M; the hazard then clears.
                    stall_F = 1'b1;
                    stall_D = 1'b1;
                    flush_E = 1'b1;
                end else if (!imem_ready) begin
                    stall_F = 1'b1;
                    flush_D = 1'b1;
                end
            end

            ST_MD_WAIT: begin
                // E is frozen, so branch and load-use terms are not looked at.
                if (md_done) begin
                    state_next = ST_RUN;
                end else begin
                    stall_F = 1'b1;
                    stall_D = 1'b1;
                    stall_E = 1'b1;
                    flush_M = 1'b1;
                end
            end

            ST_REDIRECT: begin
                // Fetch data from the old path may still be in flight: keep
                // bubbling F/D until the imem latency has drained.
                flush_D = 1'b1;
                stall_F = !imem_ready;
                if (pc_sel_E) begin
                    // A fresh redirect restarts the bubble tail.
                    flush_E         = 1'b1;
                    redirect_take   = 1'b1;
                    redir_left_next = REDIR_LOAD;
                end else if (redir_left <= 4'd1) begin
                    state_next      = ST_RUN;
                    redir_left_next = 4'd0;
                end else begin
                    redir_left_next = redir_left - 4'd1;
                end
            end

            default: begin
                state_next      = ST_RUN;
                redir_left_next = 4'd0;
            end
        endcase

        // Reset forces every control quiet in the same cycle.
        if (rst) begin
            stall_F       = 1'b0;
            stall_D       = 1'b0;
            stall_E       = 1'b0;
            flush_D       = 1'b0;
            flush_E       = 1'b0;
            flush_M       = 1'b0;
            redirect_take = 1'b0;
        end
    end

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_RUN;
            redir_left <= 4'd0;
        end else begin
            state      <= state_next;
            redir_left <= redir_left_next;
        end
    end

    // -------------------------------------------------------------------------
    // Performance counters (saturating; clear wins over increment)
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst || cnt_clr) begin
            stall_cnt <= '0;
        end else if (stall_F && (stall_cnt != CNT_MAX)) begin
            stall_cnt <= stall_cnt + CNT_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || cnt_clr) begin
            redir_cnt <= '0;
        end else if (redirect_take && (redir_cnt != CNT_MAX)) begin
            redir_cnt <= redir_cnt + CNT_ONE;
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_hazard_ctrl
//
// Self-checking bench for hazard_ctrl (REDIRECT_CYCLES=2, CNT_W=4). Directed
// scenarios follow the intended pipeline behaviour; a randomized phase runs
// against a behavioural model that tracks "waiting for mul/div" and "redirect
// bubbles still owed" as plain counts.
// Control vector order everywhere: {stall_F, stall_D, stall_E, flush_D,
// flush_E, flush_M}.
// -----------------------------------------------------------------------------
module tb_hazard_ctrl;

    localparam int RC   = 2;
    localparam int CW   = 4;
    localparam int CMAX = 15;

    // -------------------------------------------------------------------------
    // Clock / reset block
    // -------------------------------------------------------------------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic [4:0]    rs1_D, rs2_D, rd_E;
    logic          memread_E, pc_sel_E, imem_ready;
    logic          md_start_E, md_done, cnt_clr;
    logic          stall_F, stall_D, stall_E, flush_D, flush_E, flush_M;
    logic [CW-1:0] stall_cnt, redir_cnt;
    logic [5:0]    ctrl;

    assign ctrl = {stall_F, stall_D, stall_E, flush_D, flush_E, flush_M};

    hazard_ctrl #(
        .REDIRECT_CYCLES(RC),
        .CNT_W          (CW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rs1_D     (rs1_D),
        .rs2_D     (rs2_D),
        .rd_E      (rd_E),
        .memread_E (memread_E),
        .pc_sel_E  (pc_sel_E),
        .imem_ready(imem_ready),
        .md_start_E(md_start_E),
        .md_done   (md_done),
        .cnt_clr   (cnt_clr),
        .stall_F   (stall_F),
        .stall_D   (stall_D),
        .stall_E   (stall_E),
        .flush_D   (flush_D),
        .flush_E   (flush_E),
        .flush_M   (flush_M),
        .stall_cnt (stall_cnt),
        .redir_cnt (redir_cnt)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // -------------------------------------------------------------------------
    // Reference model
    // -------------------------------------------------------------------------
    bit         m_md_wait;     // a mul/div op is occupying Execute
    int         m_bubbles;     // redirect bubble cycles still owed
    int         m_stall;
    int         m_redir;
    logic [5:0] exp_ctrl;
    bit         exp_redirect;

    task automatic model_reset();
        m_md_wait = 0;
        m_bubbles = 0;
        m_stall   = 0;
        m_redir   = 0;
    endtask

    task automatic model_eval();
        bit lu;
        lu = memread_E && (rd_E != 0) && (rd_E == rs1_D || rd_E == rs2_D);
        exp_ctrl     = 6'b000000;
        exp_redirect = 0;
        if (rst) begin
            exp_ctrl = 6'b000000;
        end else if (m_md_wait) begin
            if (!md_done) exp_ctrl = 6'b111001;
        end else if (m_bubbles > 0) begin
            exp_ctrl[2] = 1'b1;
            exp_ctrl[5] = !imem_ready;
            if (pc_sel_E) begin
                exp_ctrl[1]  = 1'b1;
                exp_redirect = 1;
            end
        end else if (md_start_E && !md_done) begin
            exp_ctrl = 6'b111001;
        end else if (pc_sel_E) begin
            exp_ctrl     = 6'b000110;
            exp_redirect = 1;
        end else if (lu) begin
            exp_ctrl = 6'b110010;
        end else if (!imem_ready) begin
            exp_ctrl = 6'b100100;
        end
    endtask

    task automatic model_commit();
        if (rst) begin
            model_reset();
        end else begin
            if (cnt_clr) begin
                m_stall = 0;
                m_redir = 0;
            end else begin
                if (exp_ctrl[5] && m_stall < CMAX) m_stall = m_stall + 1;
                if (exp_redirect && m_redir < CMAX) m_redir = m_redir + 1;
            end
            if (m_md_wait) begin
                if (md_done) m_md_wait = 0;
            end else if (m_bubbles > 0) begin
                m_bubbles = pc_sel_E ? RC : m_bubbles - 1;
            end else if (md_start_E && !md_done) begin
                m_md_wait = 1;
            end else if (pc_sel_E) begin
                m_bubbles = RC;
            end
        end
    endtask

    // -------------------------------------------------------------------------
    // Driver tasks
    // Inputs change 1 time unit after posedge; outputs are sampled 3 units
    // later, well clear of both clock edges.
    // -------------------------------------------------------------------------
    task automatic drive_idle();
        rst        = 1'b0;
        rs1_D      = 5'd1;
        rs2_D      = 5'd2;
        rd_E       = 5'd0;
        memread_E  = 1'b0;
        pc_sel_E   = 1'b0;
        imem_ready = 1'b1;
        md_start_E = 1'b0;
        md_done    = 1'b0;
        cnt_clr    = 1'b0;
    endtask

    task automatic eval_wait();
        model_eval();
        #3;
    endtask

    task automatic advance();
        @(posedge clk);
        model_commit();
        #1;
    endtask

    task automatic clear_counters();
        drive_idle();
        cnt_clr = 1'b1;
        eval_wait();
        advance();
        cnt_clr = 1'b0;
    endtask

    // -------------------------------------------------------------------------
    // Scenario tasks
    // -------------------------------------------------------------------------
    task automatic test_reset();
        drive_idle();
        rst        = 1'b1;
        pc_sel_E   = 1'b1;
        imem_ready = 1'b0;
        memread_E  = 1'b1;
        rd_E       = 5'd5;
        rs1_D      = 5'd5;
        md_start_E = 1'b1;
        eval_wait();
        n_checks++;
        if (ctrl !== 6'b000000) begin
            n_fail++;
            $display("FAIL reset_ctrl: got %b expected %b", ctrl, 6'b000000);
        end
        advance();
        n_checks++;
        if (stall_cnt !== 4'd0 || redir_cnt !== 4'd0) begin
            n_fail++;
            $display("FAIL reset_cnt: got %0d/%0d expected 0/0", stall_cnt, redir_cnt);
        end
        drive_idle();
    endtask

    task automatic test_load_use();
        clear_counters();
        memread_E = 1'b1;
        rd_E      = 5'd5;
        rs1_D     = 5'd3;
        rs2_D     = 5'd5;
        eval_wait();
        n_checks++;
        if (ctrl !== 6'b110010) begin
            n_fail++;
            $display("FAIL load_use_ctrl: got %b expected %b", ctrl, 6'b110010);
        end
        advance();
        drive_idle();
        eval_wait();
        n_checks++;
        if (ctrl !== 6'b000000) begin
            n_fail++;
            $display("FAIL load_use_release: got %b expected %b", ctrl, 6'b000000);
        end
        advance();
        n_checks++;
        if (stall_cnt !== 4'd1) begin
            n_fail++;
            $display("FAIL load_use_cnt: got %0d expected 1", stall_cnt);
        end
        // Load into x0 must not stall even when the sources name x0.
        memread_E = 1'b1;
        rd_E      = 5'd0;
        rs1_D     = 5'd0;
        rs2_D     = 5'd0;
        eval_wait();
        n_checks++;
        if (ctrl !== 6'b000000) begin
            n_fail++;
            $display("FAIL load_x0: got %b expected %b", ctrl, 6'b000000);
        end
        advance();
        drive_idle();
    endtask

    task automatic test_branch();
        logic [5:0] want [0:3];
        clear_counters();
        want[0] = 6'b000110;
        want[1] = 6'b000100;
        want[2] = 6'b000100;
        want[3] = 6'b000000;
        for (int i = 0; i < 4; i++) begin
            pc_sel_E = (i == 0);
            eval_wait();
            n_checks++;
            if (ctrl !== want[i]) begin
                n_fail++;
                $display("FAIL branch_cyc%0d: got %b expected %b", i, ctrl, want[i]);
            end
            advance();
        end
        n_checks++;
        if (redir_cnt !== 4'd1) begin
            n_fail++;
            $display("FAIL branch_redir_cnt: got %0d expected 1", redir_cnt);
        end
        // Second redirect during the bubble tail restarts it; a fetch stall
        // inside the tail also holds the PC.
        want[0] = 6'b000110;
        want[1] = 6'b000110;
        want[2] = 6'b100100;
        want[3] = 6'b000100;
        for (int i = 0; i < 4; i++) begin
            pc_sel_E   = (i < 2);
            imem_ready = (i != 2);
            eval_wait();
            n_checks++;
            if (ctrl !== want[i]) begin
                n_fail++;
                $display("FAIL rebranch_cyc%0d: got %b expected %b", i, ctrl, want[i]);
            end
            advance();
        end
        drive_idle();
        eval_wait();
        n_checks++;
        if (ctrl !== 6'b000000 || redir_cnt !== 4'd3) begin
            n_fail++;
            $display("FAIL rebranch_end: got %b/%0d expected 000000/3", ctrl, redir_cnt);
        end
        advance();
    endtask

    task automatic test_muldiv();
        clear_counters();
        md_start_E = 1'b1;
        for (int i = 0; i < 5; i++) begin
            md_done = (i == 4);
            eval_wait();
            n_checks++;
            if (ctrl !== ((i == 4) ? 6'b000000 : 6'b111001)) begin
                n_fail++;
                $display("FAIL muldiv_cyc%0d: got %b expected %b", i, ctrl,
                         (i == 4) ? 6'b000000 : 6'b111001);
            end
            advance();
        end
        drive_idle();
        n_checks++;
        if (stall_cnt !== 4'd4) begin
            n_fail++;
            $display("FAIL muldiv_cnt: got %0d expected 4", stall_cnt);
        end
        md_start_E = 1'b1;
        md_done    = 1'b1;
        eval_wait();
        n_checks++;
        if (ctrl !== 6'b000000) begin
            n_fail++;
            $display("FAIL muldiv_single: got %b expected %b", ctrl, 6'b000000);
        end
        advance();
        drive_idle();
        imem_ready = 1'b0;
        eval_wait();
        n_checks++;
        if (ctrl !== 6'b100100) begin
            n_fail++;
            $display("FAIL muldiv_single_after: got %b expected %b", ctrl, 6'b100100);
        end
        advance();
        drive_idle();
    endtask

    task automatic test_priority();
        clear_counters();
        md_start_E = 1'b1;
        pc_sel_E   = 1'b1;
        memread_E  = 1'b1;
        rd_E       = 5'd7;
        rs1_D      = 5'd7;
        imem_ready = 1'b0;
        eval_wait();
        n_checks++;
        if (ctrl !== 6'b111001) begin
            n_fail++;
            $display("FAIL priority_ctrl: got %b expected %b", ctrl, 6'b111001);
        end
        advance();
        n_checks++;
        if (redir_cnt !== 4'd0) begin
            n_fail++;
            $display("FAIL priority_redir: got %0d expected 0", redir_cnt);
        end
        // Still in MD_WAIT: branch and load-use are ignored on the done cycle.
        md_done = 1'b1;
        eval_wait();
        n_checks++;
        if (ctrl !== 6'b000000) begin
            n_fail++;
            $display("FAIL priority_done: got %b expected %b", ctrl, 6'b000000);
        end
        advance();
        drive_idle();
    endtask

    task automatic test_imem_wait();
        clear_counters();
        imem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            eval_wait();
            n_checks++;
            if (ctrl !== 6'b100100) begin
                n_fail++;
                $display("FAIL imem_wait_cyc%0d: got %b expected %b", i, ctrl, 6'b100100);
            end
            advance();
        end
        drive_idle();
        eval_wait();
        n_checks++;
        if (ctrl !== 6'b000000 || stall_cnt !== 4'd3) begin
            n_fail++;
            $display("FAIL imem_wait_end: got %b/%0d expected 000000/3", ctrl, stall_cnt);
        end
        advance();
        // Enter MD_WAIT, then reset in the middle of it.
        md_start_E = 1'b1;
        eval_wait();
        advance();
        rst = 1'b1;
        eval_wait();
        n_checks++;
        if (ctrl !== 6'b000000) begin
            n_fail++;
            $display("FAIL rst_md_ctrl: got %b expected %b", ctrl, 6'b000000);
        end
        advance();
        n_checks++;
        if (stall_cnt !== 4'd0 || redir_cnt !== 4'd0) begin
            n_fail++;
            $display("FAIL rst_md_cnt: got %0d/%0d expected 0/0", stall_cnt, redir_cnt);
        end
        // Back in RUN: a fetch wait gives the RUN pattern, not the md pattern.
        drive_idle();
        imem_ready = 1'b0;
        eval_wait();
        n_checks++;
        if (ctrl !== 6'b100100) begin
            n_fail++;
            $display("FAIL rst_md_run: got %b expected %b", ctrl, 6'b100100);
        end
        advance();
        drive_idle();
    endtask

    task automatic test_saturation();
        clear_counters();
        imem_ready = 1'b0;
        for (int i = 0; i < 20; i++) begin
            eval_wait();
            advance();
        end
        n_checks++;
        if (stall_cnt !== 4'd15) begin
            n_fail++;
            $display("FAIL sat_cnt: got %0d expected 15", stall_cnt);
        end
        cnt_clr = 1'b1;
        eval_wait();
        n_checks++;
        if (ctrl !== 6'b100100) begin
            n_fail++;
            $display("FAIL sat_clr_ctrl: got %b expected %b", ctrl, 6'b100100);
        end
        advance();
        n_checks++;
        if (stall_cnt !== 4'd0) begin
            n_fail++;
            $display("FAIL sat_clr_cnt: got %0d expected 0", stall_cnt);
        end
        cnt_clr = 1'b0;
        eval_wait();
        advance();
        n_checks++;
        if (stall_cnt !== 4'd1) begin
            n_fail++;
            $display("FAIL sat_after_clr: got %0d expected 1", stall_cnt);
        end
        drive_idle();
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            rst        = ($urandom_range(0, 59) == 0);
            cnt_clr    = ($urandom_range(0, 24) == 0);
            rs1_D      = 5'($urandom_range(0, 3));
            rs2_D      = 5'($urandom_range(0, 3));
            rd_E       = 5'($urandom_range(0, 3));
            memread_E  = ($urandom_range(0, 2) == 0);
            pc_sel_E   = ($urandom_range(0, 5) == 0);
            imem_ready = ($urandom_range(0, 3) != 0);
            md_start_E = ($urandom_range(0, 5) == 0);
            md_done    = ($urandom_range(0, 2) == 0);
            // Keep stimulus legal for the pipeline: a mul/div op stays in E
            // until done, and E holds a bubble during the redirect tail.
            if (m_md_wait) md_start_E = 1'b1;
            if (m_bubbles > 0) begin
                md_start_E = 1'b0;
                memread_E  = 1'b0;
            end
            eval_wait();
            n_checks++;
            if (ctrl !== exp_ctrl) begin
                n_fail++;
                $display("FAIL rand_ctrl[%0d]: got %b expected %b", i, ctrl, exp_ctrl);
            end
            advance();
            n_checks++;
            if (stall_cnt !== CW'(m_stall) || redir_cnt !== CW'(m_redir)) begin
                n_fail++;
                $display("FAIL rand_cnt[%0d]: got %0d/%0d expected %0d/%0d",
                         i, stall_cnt, redir_cnt, m_stall, m_redir);
            end
        end
        drive_idle();
    endtask

    // -------------------------------------------------------------------------
    // Sequence and final report
    // -------------------------------------------------------------------------
    initial begin
        drive_idle();
        rst = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
        test_reset();
        test_load_use();
        test_branch();
        test_muldiv();
        test_priority();
        test_imem_wait();
        test_saturation();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
Central hazard and sequencing controller for the 5-stage RV32I pipeline. It generates the stall and flush controls for the PC register and for the F/D, D/E and E/M pipeline registers. It covers load-use hazards, taken-branch/jump redirects, instruction-memory wait states and multi-cycle mul/div occupancy. It also keeps saturating stall and redirect performance counters.

Parameters:
REDIRECT_CYCLES, 0, extra cycles flush_D stays asserted after a redirect, covering imem read latency (0..15)
CNT_W, 32, width of the performance counters

Ports:
clk  input  1  clock
rst  input  1  synchronous active-high reset
rs1_D  input  5  source reg 1 of instruction in Decode
rs2_D  input  5  source reg 2 of instruction in Decode
rd_E  input  5  destination reg of instruction in Execute
memread_E  input  1  instruction in Execute is a load
pc_sel_E  input  1  taken branch/jump resolved in Execute
imem_ready  input  1  instruction fetch data valid this cycle
md_start_E  input  1  mul/div instruction in Execute (level, held while in E)
md_done  input  1  mul/div unit result valid this cycle
cnt_clr  input  1  synchronous clear of both counters
stall_F  output  1  hold PC
stall_D  output  1  hold F/D register
stall_E  output  1  hold D/E register
flush_D  output  1  load bubble (zeros) into F/D
flush_E  output  1  load bubble into D/E
flush_M  output  1  load bubble into E/M
stall_cnt  output  CNT_W  cycles with stall_F=1
redir_cnt  output  CNT_W  accepted redirects

Behaviour:
- Reset is a decided fact: one clock (clk); reset rst is synchronous, active-high.
- While rst=1: all stall/flush outputs are 0, the FSM goes to RUN, the redirect down-counter and both counters go to 0. Reset mid-MD_WAIT or mid-REDIRECT abandons the sequence.
- Control outputs are combinational from the FSM state and current inputs. They act in the same cycle. The state and counters are registered.
- States:
  - RUN: normal operation.
  - MD_WAIT: mul/div in progress.
  - REDIRECT: extra fetch bubbles after a redirect.
- Hazard terms:
  - load_use = memread_E & (rd_E!=0) & (rd_E==rs1_D | rd_E==rs2_D).
  - md_busy = md_start_E & ~md_done.
- RUN priority, highest first:
  1. md_busy: stall_F=stall_D=stall_E=1, flush_M=1; next state MD_WAIT.
  2. pc_sel_E: flush_D=flush_E=1; redir_cnt++. If REDIRECT_CYCLES>0, next state REDIRECT with down-counter=REDIRECT_CYCLES.
  3. load_use: stall_F=stall_D=1, flush_E=1 for exactly 1 cycle. The load advances to M, so the condition clears naturally.
  4. ~imem_ready: stall_F=1, flush_D=1.
  5. Otherwise: all outputs 0.
- MD_WAIT:
  - While md_done=0: stall_F=stall_D=stall_E=1, flush_M=1.
  - On the md_done cycle: all outputs 0 and return to RUN. The mul/div result enters M on that edge.
  - pc_sel_E and load_use are ignored in MD_WAIT, because E is frozen.
- md_start_E & md_done in the same RUN cycle: single-cycle op, no stall. Lower-priority terms are evaluated normally.
- REDIRECT:
  - flush_D=1 and stall_F = ~imem_ready. The down-counter decrements each cycle; at 1, return to RUN.
  - pc_sel_E here reloads the counter, pulses flush_E, and increments redir_cnt.
  - md_busy cannot occur here, since E holds a bubble.
- Counters:
  - stall_cnt increments on every cycle with stall_F=1.
  - Both counters saturate at all-ones (no wrap).
  - cnt_clr zeroes both counters and overrides an increment in the same cycle.

Test Plan:
- Load-use: memread_E=1, rd_E=5, rs2_D=5 for 1 cycle -> stall_F=stall_D=flush_E=1 for exactly 1 cycle, stall_cnt=1. Same stimulus with rd_E=0 -> no stall.
- Branch, REDIRECT_CYCLES=2: pc_sel_E pulse -> flush_D=flush_E=1 on cycle 0, flush_D=1 on cycles 1-2, RUN on cycle 3, redir_cnt=1.
- Mul/div: md_start_E held, md_done asserted 4 cycles later -> stall_F/D/E=flush_M=1 for 4 cycles, all 0 on the done cycle, stall_cnt=4. Same-cycle start+done -> zero stall.
- Priority: md_start_E, pc_sel_E and load_use all asserted in RUN -> only the md outputs are driven, redir_cnt unchanged.
- Imem wait: imem_ready=0 for 3 cycles in RUN -> stall_F=flush_D=1 for 3 cycles. Assert rst during MD_WAIT -> outputs 0 in that cycle, RUN next, counters 0.
- Saturation: CNT_W=4, hold imem_ready=0 for 20 cycles -> stall_cnt=15. cnt_clr with an active stall -> 0.
